// File: rtl/alu_issue_ctrl.sv
// Issue/retire controller for the 16-bit ALU.
// Decodes, gates on the CCR, drives the ALU and hands results to the register file.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  input  logic [15:0] operand_a,
  input  logic [15:0] operand_b,
  output logic [2:0]  alu_control,
  output logic [15:0] bus_a,
  output logic [15:0] bus_b,
  output logic        carry_flag,
  output logic        zero_flag,
  input  logic [15:0] alu_result,
  input  logic        alu_carry,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [2:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic        illegal
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  typedef struct packed {
    logic        legal;
    logic [2:0]  op;
    logic [15:0] b;
    logic [2:0]  dst;
    logic        need_c;
    logic        need_z;
  } dec_t;

  state_t      state_q;
  logic [2:0]  alu_q;
  logic [15:0] bus_a_q;
  logic [15:0] bus_b_q;
  logic [2:0]  dst_q;
  logic        carry_q;
  logic        zero_q;
  logic        wb_valid_q;
  logic [2:0]  wb_addr_q;
  logic [15:0] wb_data_q;
  logic        illegal_q;

  logic [3:0]  opcode;
  logic [1:0]  cz;
  logic [2:0]  rb;
  logic [2:0]  rc;
  logic [15:0] imm_sx;
  logic        op_alu;
  logic        op_adi;
  logic        op_nd;
  logic        cond_ok;
  logic        add_fam;
  logic        unused_ra;
  dec_t        dec_d;

  assign opcode = instr[15:12];
  assign rb     = instr[8:6];
  assign rc     = instr[5:3];
  assign cz     = instr[1:0];
  assign imm_sx = {{10{instr[5]}}, instr[5:0]};
  assign op_alu = (opcode == 4'b0000);
  assign op_adi = (opcode == 4'b0001);
  assign op_nd  = (opcode == 4'b0010);

  // ra only selects the operand upstream
  assign unused_ra = ^instr[11:9];

  always_comb begin
    dec_d.legal  = 1'b0;
    dec_d.op     = 3'b000;
    dec_d.b      = operand_b;
    dec_d.dst    = rc;
    dec_d.need_c = 1'b0;
    dec_d.need_z = 1'b0;
    unique case (1'b1)
      (op_alu && cz == 2'b00): begin
        dec_d.legal = 1'b1;
        dec_d.op    = 3'b000;
      end
      (op_alu && cz == 2'b10): begin
        dec_d.legal  = 1'b1;
        dec_d.op     = 3'b001;
        dec_d.need_c = 1'b1;
      end
      (op_alu && cz == 2'b01): begin
        dec_d.legal  = 1'b1;
        dec_d.op     = 3'b010;
        dec_d.need_z = 1'b1;
      end
      (op_alu && cz == 2'b11): begin
        dec_d.legal = 1'b1;
        dec_d.op    = 3'b011;
        dec_d.b     = {operand_b[14:0], 1'b0};
      end
      op_adi: begin
        dec_d.legal = 1'b1;
        dec_d.op    = 3'b111;
        dec_d.b     = imm_sx;
        dec_d.dst   = rb;
      end
      (op_nd && cz == 2'b00): begin
        dec_d.legal = 1'b1;
        dec_d.op    = 3'b100;
      end
      (op_nd && cz == 2'b10): begin
        dec_d.legal  = 1'b1;
        dec_d.op     = 3'b101;
        dec_d.need_c = 1'b1;
      end
      (op_nd && cz == 2'b01): begin
        dec_d.legal  = 1'b1;
        dec_d.op     = 3'b110;
        dec_d.need_z = 1'b1;
      end
      default: ;
    endcase
  end

  assign cond_ok = !(dec_d.need_c && !carry_q) &&
                   !(dec_d.need_z && !zero_q);

  // NAND ops are 100/101/110; everything else adds
  assign add_fam = !alu_q[2] || (alu_q == 3'b111);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      alu_q      <= 3'b000;
      bus_a_q    <= 16'h0000;
      bus_b_q    <= 16'h0000;
      dst_q      <= 3'b000;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= 3'b000;
      wb_data_q  <= 16'h0000;
      illegal_q  <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (instr_valid) begin
            if (!dec_d.legal) begin
              illegal_q <= 1'b1;
            end else if (cond_ok) begin
              alu_q   <= dec_d.op;
              bus_a_q <= operand_a;
              bus_b_q <= dec_d.b;
              dst_q   <= dec_d.dst;
              state_q <= EXEC;
            end
          end
        end
        EXEC: begin
          wb_data_q  <= alu_result;
          zero_q     <= (alu_result == 16'h0000);
          if (add_fam) carry_q <= alu_carry;
          wb_addr_q  <= dst_q;
          wb_valid_q <= 1'b1;
          state_q    <= WB;
        end
        WB: begin
          if (wb_ready) begin
            wb_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign alu_control = alu_q;
  assign bus_a       = bus_a_q;
  assign bus_b       = bus_b_q;
  assign carry_flag  = carry_q;
  assign zero_flag   = zero_q;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed instructions, ALU model,
// scoreboard of expected writebacks checked by a monitor.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic [2:0]  alu_control;
  logic [15:0] bus_a;
  logic [15:0] bus_b;
  logic        carry_flag;
  logic        zero_flag;
  logic [15:0] alu_result;
  logic        alu_carry;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        illegal;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    logic        c;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .alu_control (alu_control),
    .bus_a       (bus_a),
    .bus_b       (bus_b),
    .carry_flag  (carry_flag),
    .zero_flag   (zero_flag),
    .alu_result  (alu_result),
    .alu_carry   (alu_carry),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .illegal     (illegal)
  );

  // ALU: plain add for 000/001/010/011/111, NAND for 100/101/110
  logic [16:0] sum;
  assign sum = {1'b0, bus_a} + {1'b0, bus_b};
  assign alu_result = (alu_control[2] && alu_control != 3'b111)
                      ? ~(bus_a & bus_b) : sum[15:0];
  assign alu_carry = sum[16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op,
                                     input logic [2:0] ra,
                                     input logic [2:0] rb,
                                     input logic [2:0] rc,
                                     input logic [1:0] cz);
    return {op, ra, rb, rc, 1'b0, cz};
  endfunction

  task automatic push(input logic [2:0] a, input logic [15:0] d,
                      input logic c, input logic z);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.c    = c;
    e.z    = z;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] i, input logic [15:0] a,
                       input logic [15:0] b);
    int n = 0;
    while (!instr_ready && n < 20) begin
      step();
      n++;
    end
    chk("issue_ready", {31'b0, instr_ready}, 32'd1);
    instr       = i;
    operand_a   = a;
    operand_b   = b;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  task automatic chk_reset();
    chk("rst_ready", {31'b0, instr_ready}, 32'd1);
    chk("rst_aluc", {29'b0, alu_control}, 32'd0);
    chk("rst_bus_a", {16'b0, bus_a}, 32'd0);
    chk("rst_bus_b", {16'b0, bus_b}, 32'd0);
    chk("rst_carry", {31'b0, carry_flag}, 32'd0);
    chk("rst_zero", {31'b0, zero_flag}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_addr", {29'b0, wb_addr}, 32'd0);
    chk("rst_wb_data", {16'b0, wb_data}, 32'd0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && wb_valid && wb_ready) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", {31'b0, wb_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_addr", {29'b0, wb_addr}, {29'b0, e.addr});
        chk("wb_data", {16'b0, wb_data}, {16'b0, e.data});
        chk("wb_carry", {31'b0, carry_flag}, {31'b0, e.c});
        chk("wb_zero", {31'b0, zero_flag}, {31'b0, e.z});
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    operand_a   = 16'h0000;
    operand_b   = 16'h0000;
    wb_ready    = 1'b1;
    #12;
    chk_reset();
    step();
    rst_n = 1'b1;
    step();

    // conditional ops skip with flags clear
    issue(mk(4'h0, 3'd0, 3'd0, 3'd1, 2'b10), 16'h0001, 16'h0001);
    @(negedge clk);
    chk("skip_adc_ready", {31'b0, instr_ready}, 32'd1);
    chk("skip_adc_wbv", {31'b0, wb_valid}, 32'd0);
    chk("skip_adc_ill", {31'b0, illegal}, 32'd0);
    step();
    issue(mk(4'h0, 3'd0, 3'd0, 3'd1, 2'b01), 16'h0001, 16'h0001);
    @(negedge clk);
    chk("skip_adz_ready", {31'b0, instr_ready}, 32'd1);
    chk("skip_adz_wbv", {31'b0, wb_valid}, 32'd0);
    chk("skip_adz_ill", {31'b0, illegal}, 32'd0);
    @(negedge clk);
    chk("skip_wbv2", {31'b0, wb_valid}, 32'd0);
    chk("skip_carry", {31'b0, carry_flag}, 32'd0);
    chk("skip_zero", {31'b0, zero_flag}, 32'd0);
    step();

    // ADD 0x0001 + 0xFFFF -> 0x0000, C=1 Z=1
    push(3'd3, 16'h0000, 1'b1, 1'b1);
    issue(mk(4'h0, 3'd1, 3'd2, 3'd3, 2'b00), 16'h0001, 16'hFFFF);
    @(negedge clk);
    chk("add_aluc", {29'b0, alu_control}, 32'd0);
    chk("add_bus_a", {16'b0, bus_a}, 32'h0001);
    chk("add_bus_b", {16'b0, bus_b}, 32'hFFFF);
    chk("add_exec_wbv", {31'b0, wb_valid}, 32'd0);
    chk("add_exec_ready", {31'b0, instr_ready}, 32'd0);
    @(negedge clk);
    chk("add_wb_valid", {31'b0, wb_valid}, 32'd1);
    step();

    // ADL 0x0001 + (0x8003<<1) -> 0x0007, C=0
    push(3'd4, 16'h0007, 1'b0, 1'b0);
    issue(mk(4'h0, 3'd0, 3'd0, 3'd4, 2'b11), 16'h0001, 16'h8003);
    @(negedge clk);
    chk("adl_aluc", {29'b0, alu_control}, 32'd3);
    chk("adl_bus_b", {16'b0, bus_b}, 32'h0006);
    step();

    // ADI imm -1 into rb=5: 5 + 0xFFFF -> 0x0004, C=1
    push(3'd5, 16'h0004, 1'b1, 1'b0);
    issue({4'h1, 3'd0, 3'd5, 6'h3F}, 16'h0005, 16'h0000);
    @(negedge clk);
    chk("adi_aluc", {29'b0, alu_control}, 32'd7);
    chk("adi_bus_b", {16'b0, bus_b}, 32'hFFFF);
    step();

    // NDU keeps carry, sets zero
    push(3'd6, 16'h0000, 1'b1, 1'b1);
    issue(mk(4'h2, 3'd0, 3'd0, 3'd6, 2'b00), 16'hFFFF, 16'hFFFF);
    @(negedge clk);
    chk("ndu_aluc", {29'b0, alu_control}, 32'd4);
    step();

    // NAND with cz=11 is illegal
    issue(mk(4'h2, 3'd0, 3'd0, 3'd1, 2'b11), 16'h0000, 16'h0000);
    @(negedge clk);
    chk("ill_pulse", {31'b0, illegal}, 32'd1);
    chk("ill_ready", {31'b0, instr_ready}, 32'd1);
    @(negedge clk);
    chk("ill_clear", {31'b0, illegal}, 32'd0);
    chk("ill_carry", {31'b0, carry_flag}, 32'd1);
    chk("ill_zero", {31'b0, zero_flag}, 32'd1);
    chk("ill_wbv", {31'b0, wb_valid}, 32'd0);
    step();

    // ADC executes with carry set: 2 + 3 -> 5
    push(3'd2, 16'h0005, 1'b0, 1'b0);
    issue(mk(4'h0, 3'd0, 3'd0, 3'd2, 2'b10), 16'h0002, 16'h0003);
    @(negedge clk);
    chk("adc_aluc", {29'b0, alu_control}, 32'd1);
    step();

    // ADZ skipped with zero clear
    issue(mk(4'h0, 3'd0, 3'd0, 3'd7, 2'b01), 16'h0001, 16'h0001);
    @(negedge clk);
    chk("adz_skip_wbv", {31'b0, wb_valid}, 32'd0);
    chk("adz_skip_ready", {31'b0, instr_ready}, 32'd1);
    @(negedge clk);
    chk("adz_skip_wbv2", {31'b0, wb_valid}, 32'd0);
    step();

    // stall in WB, then reset aborts it
    wb_ready = 1'b0;
    push(3'd1, 16'h1234, 1'b0, 1'b0);
    issue(mk(4'h0, 3'd0, 3'd0, 3'd1, 2'b00), 16'h1000, 16'h0234);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("stall_wbv", {31'b0, wb_valid}, 32'd1);
      chk("stall_addr", {29'b0, wb_addr}, 32'd1);
      chk("stall_data", {16'b0, wb_data}, 32'h1234);
      chk("stall_ready", {31'b0, instr_ready}, 32'd0);
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset();
    sb.delete();
    step();
    rst_n    = 1'b1;
    wb_ready = 1'b1;
    step();
    @(negedge clk);
    chk("post_rst_wbv", {31'b0, wb_valid}, 32'd0);
    chk("post_rst_ready", {31'b0, instr_ready}, 32'd1);
    chk("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
